access_sum_ctrl: RTL and testbench
==================================

# access_sum_ctrl

Parametrised access-controlled scoring block: a password entered one digit at a time gates loading of NUM_PLAYERS player registers. Their full-width sum is compared against a programmable target. It sits between the button shapers (all pulse inputs are already one-cycle pulses) and the seven-segment decoders, which consume player_val and sum_out.

## Interface
- NUM_PLAYERS, 2, number of player registers (≥2)
- DATA_W, 4, width of each player value and each password digit
- PASS_LEN, 4, password digits per entry
- PASSWORD, 16'h1234, PASS_LEN×DATA_W packed; most-significant digit is entered first
- TARGET, 15, sum value that lights match_led
- MAX_FAIL, 3, consecutive failed entries before lockout (LOCKOUT_EN only)
- LOCK_CYCLES, 8, lockout duration in clk cycles (LOCKOUT_EN only)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- digit_in  in  DATA_W  password digit being entered
- enter_pulse  in  1  one-cycle pulse; captures digit_in
- logout_pulse  in  1  one-cycle pulse; ends the session
- load_pulse  in  NUM_PLAYERS  bit i loads player i
- player_in  in  NUM_PLAYERS×DATA_W  player i is the slice [i*DATA_W +: DATA_W]
- player_val  out  NUM_PLAYERS×DATA_W  held player registers
- sum_out  out  SUM_W = DATA_W+$clog2(NUM_PLAYERS)  sum of player registers
- match_led / nomatch_led  out  1  sum == TARGET / sum != TARGET; both low while logged out
- login_led / logout_led  out  1  session state
- locked_led  out  1  lockout active

## Operation
- States: IDLE (logged out, idx=0), ENTRY (idx 1..PASS_LEN-1), GRANTED, LOCKED.
- IDLE/ENTRY, enter_pulse:
  - Compare digit_in with PASSWORD digit idx. Any mismatch sets a sticky bad flag.
  - Increment idx.
  - On the PASS_LEN-th digit:
    - bad=0: go to GRANTED and clear fail_cnt.
    - bad=1: go to IDLE and increment fail_cnt.
  - There is no early failure indication.
- load_pulse is honoured only in GRANTED. Bit i writes its player_in slice into register i. Several bits may be set in the same cycle.
- logout_pulse in GRANTED: go to IDLE and clear all player registers to 0. If logout_pulse and load_pulse arrive together, logout wins.
- logout_pulse in IDLE/ENTRY: ignored.
- sum_out is the zero-extended sum of all player registers and never overflows. It is combinational from the registers.
- match_led = GRANTED && sum_out==TARGET. nomatch_led = GRANTED && sum_out!=TARGET.
- login_led = GRANTED. logout_led = !GRANTED. locked_led = LOCKED.
- Reset values:
  - State IDLE; idx, bad, fail_cnt and lock counter 0.
  - All player registers 0, so player_val=0 and sum_out=0.
  - logout_led=1; all other LEDs 0.

## Timing
- The state change is visible in the cycle after the final enter_pulse edge.
- A load_pulse at edge n appears on player_val, sum_out and the LEDs after edge n.
- rst asserted mid-entry or mid-lockout returns to IDLE immediately; the partial entry is discarded.
- Pulses wider than one cycle are treated as one event per cycle. Feeding them is the upstream shaper's responsibility.

## Configuration
- LOCKOUT_EN defined:
  - When fail_cnt reaches MAX_FAIL, go to LOCKED.
  - In LOCKED, enter_pulse, load_pulse and logout_pulse are ignored.
  - After LOCK_CYCLES cycles, return to IDLE with fail_cnt=0.
- LOCKOUT_EN undefined:
  - No LOCKED state and no fail counter; failed entries simply return to IDLE.
  - locked_led is tied 0.
  - MAX_FAIL and LOCK_CYCLES are unused.

## Structure
- Package access_sum_pkg holds the state enum (IDLE, ENTRY, GRANTED, LOCKED) and the SUM_W width helper.
- Sub-module player_load_reg (DATA_W-wide, async reset, load enable, synchronous clear) is instantiated NUM_PLAYERS times.
- The FSM, digit comparison and summation stay in access_sum_ctrl.

## Test plan
- Reset → logout_led=1, login_led=0, match/nomatch/locked=0, player_val=0, sum_out=0.
- Enter digits 1,2,3,4 → login_led=1 one cycle after the 4th pulse. Load p0=7, p1=8 → sum_out=15 and match_led=1. Reload p1=9 → sum_out=16 and nomatch_led=1.
- Enter digits 1,2,3,5 → remains logged out and load_pulse has no effect. With LOCKOUT_EN, three such entries → locked_led=1 for 8 cycles, entries ignored; then 1,2,3,4 logs in.
- logout_pulse and load_pulse in the same cycle while logged in → logout_led=1, player_val=0.
- rst after digits 1,2 → IDLE. Then the full entry 1,2,3,4 logs in normally.
- NUM_PLAYERS=4, all players load 15 → sum_out=60 (6 bits), no overflow, nomatch_led=1.

Source files
------------

// File: rtl/access_sum_pkg.sv
// access_sum_pkg: shared types and width helper for the access-controlled
// scoring block (access_sum_ctrl and its player register slices).
package access_sum_pkg;

   // Session states of the access controller.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENTRY   = 2'd1,
      GRANTED = 2'd2,
      LOCKED  = 2'd3
   } state_e;

   // Width needed to hold the sum of num_players values of data_w bits
   // without overflow.
   function automatic int sum_width(input int num_players, input int data_w);
      return data_w + $clog2(num_players);
   endfunction

endpackage : access_sum_pkg

// File: rtl/access_sum_ctrl_player_load_reg.sv
// player_load_reg: one DATA_W-wide player score register with asynchronous
// reset, load enable and a synchronous clear that takes priority over load.
module player_load_reg #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic              clr,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] value_d;
   logic [DATA_W-1:0] value_q;

   // Next value: clear beats load, otherwise hold.
   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (load_en) begin
         value_d = d;
      end else begin
         value_d = value_q;
      end
   end

   // Storage flop with asynchronous reset to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign q = value_q;

endmodule : player_load_reg

// File: rtl/access_sum_ctrl.sv
// access_sum_ctrl: password-gated loading of NUM_PLAYERS score registers,
// full-width sum and target comparison driving the session/match LEDs.
// Optional feature macro: LOCKOUT_EN -- after MAX_FAIL consecutive failed
// entries the block locks for LOCK_CYCLES clock cycles, ignoring all pulses.
module access_sum_ctrl
   import access_sum_pkg::*;
#(
   parameter int                            NUM_PLAYERS = 2,
   parameter int                            DATA_W      = 4,
   parameter int                            PASS_LEN    = 4,
   parameter logic [PASS_LEN*DATA_W-1:0]    PASSWORD    = 16'h1234,
   parameter int                            TARGET      = 15,
   parameter int                            MAX_FAIL    = 3,
   parameter int                            LOCK_CYCLES = 8,
   localparam int                           SUM_W       = sum_width(NUM_PLAYERS, DATA_W)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATA_W-1:0]               digit_in,
   input  logic                            enter_pulse,
   input  logic                            logout_pulse,
   input  logic [NUM_PLAYERS-1:0]          load_pulse,
   input  logic [NUM_PLAYERS*DATA_W-1:0]   player_in,
   output logic [NUM_PLAYERS*DATA_W-1:0]   player_val,
   output logic [SUM_W-1:0]                sum_out,
   output logic                            match_led,
   output logic                            nomatch_led,
   output logic                            login_led,
   output logic                            logout_led,
   output logic                            locked_led
);

   localparam int IDX_W = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;

   // Reject configurations the design cannot represent.
   if (NUM_PLAYERS < 2 || PASS_LEN < 1 || MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_cfg_err
      $error("access_sum_ctrl: unsupported parameter combination");
   end

   state_e                   state_q;
   state_e                   state_d;
   logic [IDX_W-1:0]         idx_q;
   logic [IDX_W-1:0]         idx_d;
   logic                     bad_q;
   logic                     bad_d;

   logic [DATA_W-1:0]        exp_digit_s;
   logic                     bad_next_s;
   logic                     last_digit_s;
   logic [NUM_PLAYERS-1:0]   load_en_s;
   logic                     clr_players_s;
   logic [SUM_W-1:0]         sum_s;

`ifdef LOCKOUT_EN
   localparam int FAIL_W = $clog2(MAX_FAIL + 1);
   localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

   logic [FAIL_W-1:0]        fail_q;
   logic [FAIL_W-1:0]        fail_d;
   logic [FAIL_W-1:0]        fail_inc_s;
   logic [LOCK_W-1:0]        lock_q;
   logic [LOCK_W-1:0]        lock_d;
`endif

   // Select the password digit expected at the current entry position;
   // the most-significant digit is entered first.
   always_comb begin
      exp_digit_s = '0;
      for (int k = 0; k < PASS_LEN; k++) begin
         exp_digit_s = (idx_q == IDX_W'(k)) ?
                       PASSWORD[(PASS_LEN-1-k)*DATA_W +: DATA_W] : exp_digit_s;
      end
      bad_next_s   = bad_q | (digit_in != exp_digit_s);
      last_digit_s = (idx_q == IDX_W'(PASS_LEN-1));
   end

   // Session FSM next-state, entry bookkeeping and register strobes.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      bad_d         = bad_q;
      load_en_s     = '0;
      clr_players_s = 1'b0;
`ifdef LOCKOUT_EN
      fail_d        = fail_q;
      lock_d        = lock_q;
      fail_inc_s    = fail_q + FAIL_W'(1);
`endif
      case (state_q)
         IDLE, ENTRY: begin
            if (enter_pulse) begin
               if (last_digit_s) begin
                  // Entry complete: outcome only now becomes visible.
                  idx_d = '0;
                  bad_d = 1'b0;
                  if (!bad_next_s) begin
                     state_d = GRANTED;
`ifdef LOCKOUT_EN
                     fail_d  = '0;
`endif
                  end else begin
`ifdef LOCKOUT_EN
                     if (fail_inc_s == FAIL_W'(MAX_FAIL)) begin
                        state_d = LOCKED;
                        fail_d  = fail_inc_s;
                        lock_d  = '0;
                     end else begin
                        state_d = IDLE;
                        fail_d  = fail_inc_s;
                     end
`else
                     state_d = IDLE;
`endif
                  end
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  bad_d   = bad_next_s;
                  state_d = ENTRY;
               end
            end else begin
               state_d = state_q;
            end
         end
         GRANTED: begin
            // Logout wins over a simultaneous load.
            if (logout_pulse) begin
               state_d       = IDLE;
               clr_players_s = 1'b1;
            end else begin
               load_en_s = load_pulse;
            end
         end
`ifdef LOCKOUT_EN
         LOCKED: begin
            if (lock_q == LOCK_W'(LOCK_CYCLES - 1)) begin
               state_d = IDLE;
               fail_d  = '0;
               lock_d  = '0;
            end else begin
               lock_d  = lock_q + LOCK_W'(1);
            end
         end
`endif
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            bad_d   = 1'b0;
         end
      endcase
   end

   // FSM and entry-tracking registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         bad_q   <= 1'b0;
`ifdef LOCKOUT_EN
         fail_q  <= '0;
         lock_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bad_q   <= bad_d;
`ifdef LOCKOUT_EN
         fail_q  <= fail_d;
         lock_q  <= lock_d;
`endif
      end
   end

   // One held register per player.
   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
      player_load_reg #(
         .DATA_W (DATA_W)
      ) u_player_reg (
         .clk     (clk),
         .rst     (rst),
         .load_en (load_en_s[i]),
         .clr     (clr_players_s),
         .d       (player_in[i*DATA_W +: DATA_W]),
         .q       (player_val[i*DATA_W +: DATA_W])
      );
   end

   // Zero-extended sum of all player registers; SUM_W leaves no room for overflow.
   always_comb begin
      sum_s = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         sum_s = sum_s + SUM_W'(player_val[i*DATA_W +: DATA_W]);
      end
   end

   assign sum_out = sum_s;

   // LED decode from the registered session state and player registers.
   always_comb begin
      login_led   = (state_q == GRANTED);
      logout_led  = (state_q != GRANTED);
      match_led   = (state_q == GRANTED) && (sum_s == SUM_W'(TARGET));
      nomatch_led = (state_q == GRANTED) && (sum_s != SUM_W'(TARGET));
`ifdef LOCKOUT_EN
      locked_led  = (state_q == LOCKED);
`else
      locked_led  = 1'b0;
`endif
   end

endmodule : access_sum_ctrl

// File: tb/tb_access_sum_ctrl.sv
// tb_access_sum_ctrl: directed scoreboard bench for access_sum_ctrl.
// A 2-player instance carries the main scenarios; a 4-player instance shares
// the session inputs and checks the widened, non-overflowing sum.
module tb_access_sum_ctrl;

`ifdef LOCKOUT_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  digit_in = 4'd0;
   logic        enter_pulse = 1'b0;
   logic        logout_pulse = 1'b0;
   logic [1:0]  load_pulse = 2'b00;
   logic [7:0]  player_in = 8'h00;
   logic [7:0]  player_val;
   logic [4:0]  sum_out;
   logic        match_led, nomatch_led, login_led, logout_led, locked_led;

   logic [3:0]  load_pulse4 = 4'h0;
   logic [15:0] player_in4 = 16'h0000;
   logic [15:0] player_val4;
   logic [5:0]  sum_out4;
   logic        match4, nomatch4, login4, logout4, locked4;

   typedef struct {
      string       nm;
      bit          sel;
      logic        lin;
      logic        lout;
      logic        mt;
      logic        nmt;
      logic        lk;
      logic [15:0] pv;
      logic [5:0]  sm;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   access_sum_ctrl dut (
      .clk (clk), .rst (rst), .digit_in (digit_in), .enter_pulse (enter_pulse),
      .logout_pulse (logout_pulse), .load_pulse (load_pulse), .player_in (player_in),
      .player_val (player_val), .sum_out (sum_out), .match_led (match_led),
      .nomatch_led (nomatch_led), .login_led (login_led), .logout_led (logout_led),
      .locked_led (locked_led)
   );

   access_sum_ctrl #(.NUM_PLAYERS(4)) dut4 (
      .clk (clk), .rst (rst), .digit_in (digit_in), .enter_pulse (enter_pulse),
      .logout_pulse (logout_pulse), .load_pulse (load_pulse4), .player_in (player_in4),
      .player_val (player_val4), .sum_out (sum_out4), .match_led (match4),
      .nomatch_led (nomatch4), .login_led (login4), .logout_led (logout4),
      .locked_led (locked4)
   );

   // Monitor: on every falling edge, compare each queued expectation with the DUT.
   initial begin
      exp_t e;
      logic [20:0] act;
      logic [20:0] req;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.sel) begin
               act = {login4, logout4, match4, nomatch4, locked4, player_val4};
            end else begin
               act = {login_led, logout_led, match_led, nomatch_led, locked_led, 8'h00, player_val};
            end
            req = {e.lin, e.lout, e.mt, e.nmt, e.lk, e.pv};
            n_total++;
            if (act !== req) begin
               n_bad++;
               $display("FAIL %s: got {login,logout,match,nomatch,locked,pv}=%b_%h, expected %b_%h",
                        e.nm, act[20:16], act[15:0], req[20:16], req[15:0]);
            end
            n_total++;
            if ((e.sel ? sum_out4 : {1'b0, sum_out}) !== e.sm) begin
               n_bad++;
               $display("FAIL %s_sum: got %0d, expected %0d",
                        e.nm, e.sel ? sum_out4 : {1'b0, sum_out}, e.sm);
            end
         end
      end
   end

   // Wait (bounded) until the monitor has consumed all pending expectations.
   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_total++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic expect_out(input string nm, input bit sel, input logic lin,
                             input logic mt, input logic nmt, input logic lk,
                             input logic [15:0] pv, input logic [5:0] sm);
      exp_t e;
      e.nm = nm; e.sel = sel; e.lin = lin; e.lout = ~lin; e.mt = mt;
      e.nmt = nmt; e.lk = lk; e.pv = pv; e.sm = sm;
      exp_q.push_back(e);
      drain();
   endtask

   // One-cycle enter pulse carrying digit d, captured on the next rising edge.
   task automatic press(input logic [3:0] d);
      digit_in    = d;
      enter_pulse = 1'b1;
      @(posedge clk);
      #1;
      enter_pulse = 1'b0;
   endtask

   task automatic bad_entry(input string nm);
      press(4'd1); press(4'd2); press(4'd3); press(4'd5);
      expect_out(nm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);
   endtask

   task automatic good_entry(input string nm);
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      expect_out(nm, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 6'd0);
   endtask

   // Global time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state on both instances.
      @(negedge clk);
      #1;
      expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);
      expect_out("reset4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);
      rst = 1'b0;

      // Correct password: logged out until the 4th digit, then logged in.
      press(4'd1);
      expect_out("entry_d1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);
      press(4'd2);
      expect_out("entry_d2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);
      press(4'd3);
      expect_out("entry_d3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);
      press(4'd4);
      expect_out("login", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 6'd0);

      // Load p0=7, p1=8 together: 15 matches the target.
      load_pulse = 2'b11; player_in = {4'd8, 4'd7};
      @(posedge clk); #1; load_pulse = 2'b00;
      expect_out("load_match", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0087, 6'd15);

      // Reload only p1=9: 16 misses the target; p0 must hold.
      load_pulse = 2'b10; player_in = {4'd9, 4'd3};
      @(posedge clk); #1; load_pulse = 2'b00;
      expect_out("reload_nomatch", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0097, 6'd16);

      // Logout and load in the same cycle: logout wins, registers clear.
      logout_pulse = 1'b1; load_pulse = 2'b11; player_in = 8'hFF;
      @(posedge clk); #1; logout_pulse = 1'b0; load_pulse = 2'b00;
      expect_out("logout_wins", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);

      // Wrong last digit: stays logged out; loads are ignored.
      bad_entry("bad_entry1");
      load_pulse = 2'b11; player_in = 8'hAA;
      @(posedge clk); #1; load_pulse = 2'b00;
      expect_out("load_ignored", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);

      // Two more failures: the third consecutive one locks when lockout is built in.
      bad_entry("bad_entry2");
      press(4'd1); press(4'd2); press(4'd3); press(4'd5);
      expect_out("third_fail", 1'b0, 1'b0, 1'b0, 1'b0, LOCK_ON, 16'h0000, 6'd0);
      if (LOCK_ON) begin
         // Pulses of every kind are ignored for the remaining locked cycles.
         for (int k = 1; k < 8; k++) begin
            digit_in = 4'd1; enter_pulse = 1'b1; logout_pulse = 1'b1;
            load_pulse = 2'b11; player_in = 8'h55;
            @(posedge clk); #1;
            enter_pulse = 1'b0; logout_pulse = 1'b0; load_pulse = 2'b00;
            expect_out("lock_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 6'd0);
         end
         @(posedge clk); #1;
         expect_out("lock_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);
      end
      good_entry("login_after_fails");

      // Plain logout, then logout while logged out is ignored.
      logout_pulse = 1'b1;
      @(posedge clk); #1; logout_pulse = 1'b0;
      expect_out("logout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);
      logout_pulse = 1'b1;
      @(posedge clk); #1; logout_pulse = 1'b0;
      expect_out("logout_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);

      // Reset mid-entry discards the partial entry.
      press(4'd1); press(4'd2);
      rst = 1'b1;
      expect_out("rst_mid_entry", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);
      rst = 1'b0;
      press(4'd1); press(4'd2);
      expect_out("reentry_d2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'd0);
      press(4'd3); press(4'd4);
      expect_out("login_after_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 6'd0);

      // Four players all at 15: 60 fits in 6 bits and misses the target.
      load_pulse4 = 4'hF; player_in4 = 16'hFFFF;
      @(posedge clk); #1; load_pulse4 = 4'h0;
      expect_out("sum4_max", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 6'd60);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_access_sum_ctrl
